// File: rtl/conv_mode_ctrl.sv
// -----------------------------------------------------------------------------
// conv_mode_ctrl
//
// Run-time mode sequencer for the camera convolution datapath. Picks between
// passthrough (0), vertical-edge (1) and horizontal-edge (2) filtering. Mode
// requests may arrive at any time. They are held in a pending register and
// applied only on the cycle after start-of-frame, so a frame never mixes
// modes. Switching into a filter mode pulses a line-buffer flush. It then masks
// the datapath output valid until PRIME_LINES complete lines have refilled
// the 3x3 window.
//
// Ports
//   iCLK, iRST        clock, asynchronous active-low reset
//   iX_Cont, iY_Cont  column / row of the current pixel beat
//   iDVAL             pixel valid
//   iMODE_REQ         requested mode (3 is reserved and always rejected)
//   iMODE_VALID       single-cycle request strobe
//   oMODE             active mode, output mux select
//   oCONV_EN          high while a filter mode is active
//   oFLUSH            one-cycle line-buffer clear pulse
//   oOUT_EN           gate for the datapath output valid
//   oBUSY             high while a request is pending or the window is priming
//   oREQ_REJ          one-cycle pulse for a rejected request
//   oFRAME_CNT        frames started since reset (wraps)
// -----------------------------------------------------------------------------
module conv_mode_ctrl #(
    parameter int H_ACTIVE    = 640,
    parameter int PRIME_LINES = 2,
    parameter int FCNT_W      = 16
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic [10:0]       iX_Cont,
    input  logic [10:0]       iY_Cont,
    input  logic              iDVAL,
    input  logic [1:0]        iMODE_REQ,
    input  logic              iMODE_VALID,
    output logic [1:0]        oMODE,
    output logic              oCONV_EN,
    output logic              oFLUSH,
    output logic              oOUT_EN,
    output logic              oBUSY,
    output logic              oREQ_REJ,
    output logic [FCNT_W-1:0] oFRAME_CNT
);

    // Enough bits to hold PRIME_LINES-1. The terminal count is detected one
    // eol early, so PRIME_LINES itself is never stored.
    localparam int LC_W = (PRIME_LINES > 1) ? $clog2(PRIME_LINES + 1) : 1;

    localparam logic [1:0] MODE_PASS = 2'd0;
    localparam logic [1:0] MODE_RSVD = 2'd3;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_ARMED = 2'd1,
        S_PRIME = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         pending_q, pending_d;
    logic [1:0]         mode_q, mode_d;
    logic               flush_q, flush_d;
    logic               out_en_q, out_en_d;
    logic               rej_q, rej_d;
    logic [LC_W-1:0]    line_cnt_q, line_cnt_d;
    logic               conv_en_q;
    logic               busy_q;
    logic [FCNT_W-1:0]  fcnt_q;

    logic sof;
    logic eol;
    logic req_rsvd;

    assign sof      = iDVAL && (iX_Cont == 11'd0) && (iY_Cont == 11'd0);
    assign eol      = iDVAL && (iX_Cont == 11'(H_ACTIVE - 1));
    assign req_rsvd = (iMODE_REQ == MODE_RSVD);

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    // NOTE: every signal written here gets a default first. Otherwise a path
    // that leaves a signal unassigned would infer a latch.
    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        mode_d     = mode_q;
        flush_d    = 1'b0;
        out_en_d   = out_en_q;
        rej_d      = 1'b0;
        line_cnt_d = line_cnt_q;

        unique case (state_q)
            S_RUN: begin
                // A request equal to the live mode is dropped silently. A
                // request that coincides with sof is still only armed here. It
                // takes effect at the following sof.
                if (iMODE_VALID) begin
                    if (req_rsvd) begin
                        rej_d = 1'b1;
                    end else if (iMODE_REQ != mode_q) begin
                        pending_d = iMODE_REQ;
                        state_d   = S_ARMED;
                    end
                end
            end

            S_ARMED: begin
                if (sof) begin
                    // The older pending mode wins over a request that arrives
                    // in the same cycle as sof.
                    if (iMODE_VALID) begin
                        rej_d = 1'b1;
                    end
                    if (pending_q == mode_q) begin
                        state_d = S_RUN;
                    end else begin
                        mode_d  = pending_q;
                        flush_d = 1'b1;
                        if (pending_q == MODE_PASS) begin
                            state_d  = S_RUN;
                            out_en_d = 1'b1;
                        end else begin
                            state_d    = S_PRIME;
                            out_en_d   = 1'b0;
                            line_cnt_d = '0;
                        end
                    end
                end else if (iMODE_VALID) begin
                    // Last request wins, even one that matches the live mode.
                    if (req_rsvd) begin
                        rej_d = 1'b1;
                    end else begin
                        pending_d = iMODE_REQ;
                    end
                end
            end

            S_PRIME: begin
                if (iMODE_VALID) begin
                    rej_d = 1'b1;
                end
                // A short frame restarts priming without another flush.
                if (sof) begin
                    line_cnt_d = '0;
                end else if (eol) begin
                    if (line_cnt_q == LC_W'(PRIME_LINES - 1)) begin
                        out_en_d   = 1'b1;
                        state_d    = S_RUN;
                        line_cnt_d = '0;
                    end else begin
                        line_cnt_d = line_cnt_q + LC_W'(1);
                    end
                end
            end

            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers. Every output comes straight from a flop.
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only. All flops
    // then sample the pre-edge values together, whatever the statement order.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_q    <= S_RUN;
            pending_q  <= MODE_PASS;
            mode_q     <= MODE_PASS;
            flush_q    <= 1'b0;
            out_en_q   <= 1'b1;
            rej_q      <= 1'b0;
            line_cnt_q <= '0;
            conv_en_q  <= 1'b0;
            busy_q     <= 1'b0;
            fcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            mode_q     <= mode_d;
            flush_q    <= flush_d;
            out_en_q   <= out_en_d;
            rej_q      <= rej_d;
            line_cnt_q <= line_cnt_d;
            conv_en_q  <= (mode_d != MODE_PASS);
            busy_q     <= (state_d != S_RUN);
            if (sof) begin
                fcnt_q <= fcnt_q + FCNT_W'(1);
            end
        end
    end

    assign oMODE      = mode_q;
    assign oCONV_EN   = conv_en_q;
    assign oFLUSH     = flush_q;
    assign oOUT_EN    = out_en_q;
    assign oBUSY      = busy_q;
    assign oREQ_REJ   = rej_q;
    assign oFRAME_CNT = fcnt_q;

endmodule

// File: tb/tb_conv_mode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_conv_mode_ctrl
//
// Directed bench for conv_mode_ctrl. Frames are streamed as 640 active beats
// per row, each followed by one blanking beat (iDVAL=0, x=639). Mode requests
// are injected at chosen (x,y) positions. Each frame records what the outputs
// did, and every scenario task compares those records against hand-computed
// values. The beat index inside a frame is y*641 + x, with the blanking beat
// at x=640.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_conv_mode_ctrl;

    localparam int FCNT_W = 4;   // small so the wrap is reachable quickly
    localparam int ROW_BEATS = 641;

    logic              iCLK = 1'b0;
    logic              iRST = 1'b0;
    logic [10:0]       iX_Cont = '0;
    logic [10:0]       iY_Cont = '0;
    logic              iDVAL = 1'b0;
    logic [1:0]        iMODE_REQ = '0;
    logic              iMODE_VALID = 1'b0;
    logic [1:0]        oMODE;
    logic              oCONV_EN;
    logic              oFLUSH;
    logic              oOUT_EN;
    logic              oBUSY;
    logic              oREQ_REJ;
    logic [FCNT_W-1:0] oFRAME_CNT;

    int total = 0;
    int bad   = 0;

    conv_mode_ctrl #(
        .H_ACTIVE    (640),
        .PRIME_LINES (2),
        .FCNT_W      (FCNT_W)
    ) dut (
        .iCLK        (iCLK),
        .iRST        (iRST),
        .iX_Cont     (iX_Cont),
        .iY_Cont     (iY_Cont),
        .iDVAL       (iDVAL),
        .iMODE_REQ   (iMODE_REQ),
        .iMODE_VALID (iMODE_VALID),
        .oMODE       (oMODE),
        .oCONV_EN    (oCONV_EN),
        .oFLUSH      (oFLUSH),
        .oOUT_EN     (oOUT_EN),
        .oBUSY       (oBUSY),
        .oREQ_REJ    (oREQ_REJ),
        .oFRAME_CNT  (oFRAME_CNT)
    );

    always #5 iCLK = ~iCLK;

    // Request injection table for the next frame.
    bit         inj_en   [3];
    int         inj_x    [3];
    int         inj_y    [3];
    logic [1:0] inj_mode [3];

    // Per-frame observations.
    int          flush_n, rej_n, en_rise;
    bit          en_low_seen, mode_stable, got_inj;
    logic [1:0]  mode_sof, mode_inj;
    logic        conv_sof, en_sof, busy_sof, busy_inj;
    logic [FCNT_W-1:0] fcnt_sof;

    // One beat: drive on the falling edge, sample 1 ns after the rising edge.
    task automatic pix(input int x, input int y, input bit dv,
                       input bit mv, input logic [1:0] mr);
        @(negedge iCLK);
        iX_Cont     = 11'(x);
        iY_Cont     = 11'(y);
        iDVAL       = dv;
        iMODE_VALID = mv;
        iMODE_REQ   = mr;
        @(posedge iCLK);
        #1;
    endtask

    task automatic set_inj(input int k, input int x, input int y, input logic [1:0] m);
        inj_en[k]   = 1'b1;
        inj_x[k]    = x;
        inj_y[k]    = y;
        inj_mode[k] = m;
    endtask

    task automatic run_frame(input int rows);
        logic en_prev;
        int   idx;
        bit   mv;
        logic [1:0] mr;
        flush_n     = 0;
        rej_n       = 0;
        en_rise     = -1;
        en_low_seen = 1'b0;
        mode_stable = 1'b1;
        got_inj     = 1'b0;
        en_prev     = oOUT_EN;
        for (int y = 0; y < rows; y++) begin
            for (int x = 0; x < ROW_BEATS; x++) begin
                mv = 1'b0;
                mr = 2'd0;
                for (int k = 0; k < 3; k++) begin
                    if (inj_en[k] && inj_x[k] == x && inj_y[k] == y && x < 640) begin
                        mv = 1'b1;
                        mr = inj_mode[k];
                    end
                end
                pix((x < 640) ? x : 639, y, (x < 640), mv, mr);
                idx = y * ROW_BEATS + x;
                if (oFLUSH)   flush_n++;
                if (oREQ_REJ) rej_n++;
                if (!oOUT_EN) en_low_seen = 1'b1;
                if (!en_prev && oOUT_EN && en_rise < 0) en_rise = idx;
                en_prev = oOUT_EN;
                if (idx == 0) begin
                    mode_sof = oMODE;
                    conv_sof = oCONV_EN;
                    en_sof   = oOUT_EN;
                    busy_sof = oBUSY;
                    fcnt_sof = oFRAME_CNT;
                end else if (oMODE !== mode_sof) begin
                    mode_stable = 1'b0;
                end
                if (mv && !got_inj) begin
                    got_inj  = 1'b1;
                    busy_inj = oBUSY;
                    mode_inj = oMODE;
                end
            end
        end
        for (int k = 0; k < 3; k++) inj_en[k] = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        iRST = 1'b0;
        repeat (3) @(posedge iCLK);
        #1;
        total++; if (oMODE !== 2'd0)       begin bad++; $display("FAIL rst_mode: got %0d want 0", oMODE); end
        total++; if (oCONV_EN !== 1'b0)    begin bad++; $display("FAIL rst_conv: got %0b want 0", oCONV_EN); end
        total++; if (oFLUSH !== 1'b0)      begin bad++; $display("FAIL rst_flush: got %0b want 0", oFLUSH); end
        total++; if (oOUT_EN !== 1'b1)     begin bad++; $display("FAIL rst_out_en: got %0b want 1", oOUT_EN); end
        total++; if (oBUSY !== 1'b0)       begin bad++; $display("FAIL rst_busy: got %0b want 0", oBUSY); end
        total++; if (oREQ_REJ !== 1'b0)    begin bad++; $display("FAIL rst_rej: got %0b want 0", oREQ_REJ); end
        total++; if (oFRAME_CNT !== 4'd0)  begin bad++; $display("FAIL rst_fcnt: got %0d want 0", oFRAME_CNT); end
        @(negedge iCLK);
        iRST = 1'b1;
    endtask

    task automatic test_passthrough();
        run_frame(4);  // frame 1
        total++; if (mode_sof !== 2'd0)  begin bad++; $display("FAIL pass_mode: got %0d want 0", mode_sof); end
        total++; if (en_low_seen)        begin bad++; $display("FAIL pass_out_en: got low want always 1"); end
        total++; if (fcnt_sof !== 4'd1)  begin bad++; $display("FAIL pass_fcnt: got %0d want 1", fcnt_sof); end
        total++; if (flush_n != 0)       begin bad++; $display("FAIL pass_flush: got %0d want 0", flush_n); end
    endtask

    task automatic test_switch_vertical();
        set_inj(0, 100, 2, 2'd1);
        run_frame(4);  // frame 2: request armed
        total++; if (busy_inj !== 1'b1)  begin bad++; $display("FAIL arm_busy: got %0b want 1", busy_inj); end
        total++; if (mode_inj !== 2'd0)  begin bad++; $display("FAIL arm_mode_held: got %0d want 0", mode_inj); end
        total++; if (!mode_stable || oMODE !== 2'd0) begin bad++; $display("FAIL arm_mode_frame: got %0d want 0", oMODE); end
        run_frame(4);  // frame 3: applied at sof
        total++; if (mode_sof !== 2'd1)  begin bad++; $display("FAIL vert_mode: got %0d want 1", mode_sof); end
        total++; if (conv_sof !== 1'b1)  begin bad++; $display("FAIL vert_conv: got %0b want 1", conv_sof); end
        total++; if (flush_n != 1)       begin bad++; $display("FAIL vert_flush: got %0d want 1", flush_n); end
        total++; if (en_sof !== 1'b0)    begin bad++; $display("FAIL vert_out_en_sof: got %0b want 0", en_sof); end
        total++; if (en_rise != 1280)    begin bad++; $display("FAIL vert_out_en_rise: got %0d want 1280", en_rise); end
        total++; if (oBUSY !== 1'b0)     begin bad++; $display("FAIL vert_busy_end: got %0b want 0", oBUSY); end
        total++; if (fcnt_sof !== 4'd3)  begin bad++; $display("FAIL vert_fcnt: got %0d want 3", fcnt_sof); end
    endtask

    task automatic test_last_wins_and_reject();
        set_inj(0, 10, 1, 2'd0);
        set_inj(1, 20, 1, 2'd1);
        set_inj(2, 30, 1, 2'd2);
        run_frame(4);  // frame 4
        total++; if (rej_n != 0)         begin bad++; $display("FAIL lw_rej: got %0d want 0", rej_n); end
        total++; if (!mode_stable)       begin bad++; $display("FAIL lw_mode_frame: got change want stable"); end
        set_inj(0, 5, 0, 2'd1);          // lands in PRIME
        set_inj(1, 5, 3, 2'd3);          // reserved, back in RUN
        run_frame(4);  // frame 5
        total++; if (mode_sof !== 2'd2)  begin bad++; $display("FAIL lw_mode: got %0d want 2", mode_sof); end
        total++; if (flush_n != 1)       begin bad++; $display("FAIL lw_flush: got %0d want 1", flush_n); end
        total++; if (rej_n != 2)         begin bad++; $display("FAIL rej_count: got %0d want 2", rej_n); end
        total++; if (!mode_stable || oMODE !== 2'd2) begin bad++; $display("FAIL rej_mode: got %0d want 2", oMODE); end
        total++; if (en_rise != 1280)    begin bad++; $display("FAIL lw_out_en_rise: got %0d want 1280", en_rise); end
        total++; if (fcnt_sof !== 4'd5)  begin bad++; $display("FAIL lw_fcnt: got %0d want 5", fcnt_sof); end
    endtask

    task automatic test_same_mode_no_flush();
        set_inj(0, 3, 0, 2'd1);
        set_inj(1, 4, 0, 2'd2);
        run_frame(4);  // frame 6
        total++; if (busy_inj !== 1'b1)  begin bad++; $display("FAIL same_busy: got %0b want 1", busy_inj); end
        run_frame(4);  // frame 7
        total++; if (flush_n != 0)       begin bad++; $display("FAIL same_flush: got %0d want 0", flush_n); end
        total++; if (mode_sof !== 2'd2)  begin bad++; $display("FAIL same_mode: got %0d want 2", mode_sof); end
        total++; if (en_low_seen)        begin bad++; $display("FAIL same_out_en: got low want always 1"); end
        total++; if (busy_sof !== 1'b0)  begin bad++; $display("FAIL same_busy_sof: got %0b want 0", busy_sof); end
    endtask

    task automatic test_to_pass();
        set_inj(0, 100, 2, 2'd0);
        run_frame(4);  // frame 8
        run_frame(4);  // frame 9
        total++; if (mode_sof !== 2'd0)  begin bad++; $display("FAIL topass_mode: got %0d want 0", mode_sof); end
        total++; if (conv_sof !== 1'b0)  begin bad++; $display("FAIL topass_conv: got %0b want 0", conv_sof); end
        total++; if (flush_n != 1)       begin bad++; $display("FAIL topass_flush: got %0d want 1", flush_n); end
        total++; if (en_low_seen)        begin bad++; $display("FAIL topass_out_en: got low want always 1"); end
        total++; if (busy_sof !== 1'b0)  begin bad++; $display("FAIL topass_busy: got %0b want 0", busy_sof); end
        total++; if (fcnt_sof !== 4'd9)  begin bad++; $display("FAIL topass_fcnt: got %0d want 9", fcnt_sof); end
    endtask

    task automatic test_sof_reject_and_reset();
        set_inj(0, 50, 3, 2'd1);
        run_frame(4);  // frame 10
        set_inj(0, 0, 0, 2'd2);          // coincides with sof while ARMED
        run_frame(4);  // frame 11
        total++; if (rej_n != 1)         begin bad++; $display("FAIL sofrej_rej: got %0d want 1", rej_n); end
        total++; if (mode_sof !== 2'd1)  begin bad++; $display("FAIL sofrej_mode: got %0d want 1", mode_sof); end
        total++; if (!mode_stable)       begin bad++; $display("FAIL sofrej_mode_frame: got change want stable"); end
        set_inj(0, 100, 2, 2'd2);
        run_frame(4);  // frame 12
        run_frame(1);  // frame 13: one eol only, still priming
        total++; if (oBUSY !== 1'b1 || oOUT_EN !== 1'b0) begin bad++; $display("FAIL prime_mid: got busy=%0b en=%0b want busy=1 en=0", oBUSY, oOUT_EN); end
        total++; if (fcnt_sof !== 4'd13) begin bad++; $display("FAIL prime_fcnt: got %0d want 13", fcnt_sof); end
        #3 iRST = 1'b0;
        #1;
        total++; if (oMODE !== 2'd0)     begin bad++; $display("FAIL arst_mode: got %0d want 0", oMODE); end
        total++; if (oCONV_EN !== 1'b0)  begin bad++; $display("FAIL arst_conv: got %0b want 0", oCONV_EN); end
        total++; if (oOUT_EN !== 1'b1)   begin bad++; $display("FAIL arst_out_en: got %0b want 1", oOUT_EN); end
        total++; if (oBUSY !== 1'b0)     begin bad++; $display("FAIL arst_busy: got %0b want 0", oBUSY); end
        total++; if (oFRAME_CNT !== 4'd0) begin bad++; $display("FAIL arst_fcnt: got %0d want 0", oFRAME_CNT); end
        repeat (2) @(posedge iCLK);
        #2 iRST = 1'b1;
        run_frame(2);  // frame 1 after reset: nothing pending survives
        total++; if (en_low_seen)        begin bad++; $display("FAIL post_rst_out_en: got low want always 1"); end
        total++; if (flush_n != 0)       begin bad++; $display("FAIL post_rst_flush: got %0d want 0", flush_n); end
        total++; if (mode_sof !== 2'd0)  begin bad++; $display("FAIL post_rst_mode: got %0d want 0", mode_sof); end
        total++; if (fcnt_sof !== 4'd1)  begin bad++; $display("FAIL post_rst_fcnt: got %0d want 1", fcnt_sof); end
    endtask

    task automatic test_fcnt_wrap();
        // Counter is 1 here; 14 more sofs reach 15 and the 15th wraps to 0.
        for (int i = 0; i < 14; i++) begin
            pix(0, 0, 1'b1, 1'b0, 2'd0);
            pix(7, 0, 1'b0, 1'b0, 2'd0);
        end
        total++; if (oFRAME_CNT !== 4'd15) begin bad++; $display("FAIL fcnt_top: got %0d want 15", oFRAME_CNT); end
        pix(0, 0, 1'b1, 1'b0, 2'd0);
        total++; if (oFRAME_CNT !== 4'd0)  begin bad++; $display("FAIL fcnt_wrap: got %0d want 0", oFRAME_CNT); end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) inj_en[k] = 1'b0;
        test_reset();
        test_passthrough();
        test_switch_vertical();
        test_last_wins_and_reject();
        test_same_mode_no_flush();
        test_to_pass();
        test_sof_reject_and_reset();
        test_fcnt_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
